// File: rtl/display_scan_driver_pkg.sv
// Shared constants, converter state type and value clamp for the 4-digit scan driver.
package display_pkg;

  localparam int unsigned DIGITS     = 4;
  localparam int unsigned VALUE_W    = 14;
  localparam int unsigned VALUE_MAX  = 9999;
  localparam int unsigned BCD_W      = 16;
  localparam int unsigned ITERATIONS = 14;

  typedef enum logic [0:0] {IDLE, SHIFT} conv_state_e;

  function automatic logic [VALUE_W-1:0] clamp_value(logic [VALUE_W-1:0] v);
    return (v > VALUE_W'(VALUE_MAX)) ? VALUE_W'(VALUE_MAX) : v;
  endfunction

endpackage

// File: rtl/display_scan_driver_if.sv
// Host-side request/status and Standard_7448-side outputs of the scan driver.
interface display_scan_driver_if;
  import display_pkg::*;

  logic [VALUE_W-1:0] value;
  logic               update;
  logic               lamp_test;
  logic               blank;
  logic               busy;
  logic [3:0]         data;
  logic               LT;
  logic               RBI;
  logic               BI;
  logic [DIGITS-1:0]  digit_sel;

  modport master (
    output value, update, lamp_test, blank,
    input  busy, data, LT, RBI, BI, digit_sel
  );

  modport slave (
    input  value, update, lamp_test, blank,
    output busy, data, LT, RBI, BI, digit_sel
  );

endinterface

// File: rtl/display_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock, 14 iterations per value.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [VALUE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  conv_state_e        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   adj, bcd_shift;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == SHIFT) && (cnt_q == 4'(ITERATIONS - 1));
  // Result of the final iteration, so the caller can latch it on the done edge.
  assign bcd  = bcd_shift;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bin_d   = bin;
          bcd_d   = '0;
        end
      end
      SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = {bin_q[VALUE_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (done) begin
          if (start) begin
            cnt_d = '0;
            bin_d = bin;
            bcd_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

endmodule

// File: rtl/display_scan_driver.sv
// Captures a binary value, converts it to BCD and scans four digits into a Standard_7448
// decoder with leading-zero blanking, lamp test and blank.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                 clk,
  input logic                 rst_n,
  display_scan_driver_if.slave bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = $clog2(DIGITS);

  logic [VALUE_W-1:0] clamped, cap_q, cap_d, eng_bin;
  logic               pending_q, pending_d;
  logic [BCD_W-1:0]   disp_q, disp_d, eng_bcd;
  logic               eng_start, eng_busy, eng_done;
  logic [PW-1:0]      presc_q, presc_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DIGITS-1:0]  sel_q, sel_d;
  logic [3:0]         data_q, data_d;
  logic               rbi_q, rbi_d, lt_q, bi_q;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (eng_start),
    .bin   (eng_bin),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  always_comb begin
    clamped = clamp_value(bus.value);
    // While busy, a restart happens only on the final iteration, taking the newest capture.
    eng_start = eng_busy ? (eng_done && (pending_q || bus.update)) : bus.update;
    eng_bin   = bus.update ? clamped : cap_q;
    cap_d     = bus.update ? clamped : cap_q;
    pending_d = eng_start ? 1'b0 : (bus.update ? 1'b1 : pending_q);
    disp_d    = eng_done ? eng_bcd : disp_q;
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + IW'(1);
    end
    sel_d  = DIGITS'(1) << idx_d;
    data_d = disp_q[4*idx_d +: 4];
    // Only the upper digits may blank, and only while every digit above them is zero.
    case (idx_d)
      IW'(3):  rbi_d = 1'b1;
      IW'(2):  rbi_d = (disp_q[15:12] == 4'd0);
      IW'(1):  rbi_d = (disp_q[15:8] == 8'd0);
      default: rbi_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q     <= '0;
      pending_q <= 1'b0;
      disp_q    <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
      sel_q     <= DIGITS'(1);
      data_q    <= '0;
      rbi_q     <= 1'b0;
      lt_q      <= 1'b0;
      bi_q      <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      rbi_q     <= rbi_d;
      lt_q      <= bus.lamp_test;
      bi_q      <= bus.blank & ~bus.lamp_test;
    end
  end

  assign bus.busy      = eng_busy;
  assign bus.data      = data_q;
  assign bus.RBI       = rbi_q;
  assign bus.LT        = lt_q;
  assign bus.BI        = bi_q;
  assign bus.digit_sel = sel_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench: stimulus queues the value expected on the display, a monitor checks a full
// scan rotation against a decimal reference model each time a conversion publishes.
module tb_display_scan_driver;
  import display_pkg::*;

  localparam int unsigned S = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  display_scan_driver_if bus ();

  display_scan_driver #(.SCAN_DIV(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  bit mon_active = 1'b0;
  int dir_vals[5] = '{7, 0, 1005, 12000, 9999};

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference model: decimal digit i of the clamped value.
  function automatic int digit_of(input int v, input int i);
    int c = (v > 9999) ? 9999 : v;
    for (int k = 0; k < i; k++) c = c / 10;
    return c % 10;
  endfunction

  function automatic int rbi_of(input int v, input int i);
    if (i == 3) return 1;
    if (i == 2) return (digit_of(v, 3) == 0) ? 1 : 0;
    if (i == 1) return (digit_of(v, 3) == 0 && digit_of(v, 2) == 0) ? 1 : 0;
    return 0;
  endfunction

  function automatic int sel_index(input logic [3:0] sel);
    int r = 0;
    for (int b = 0; b < 4; b++) if (sel[b]) r = b;
    return r;
  endfunction

  task automatic check_scan(input int v);
    logic [3:0] prev;
    bit found = 1'b0;
    int idx, expw, got;
    prev = bus.digit_sel;
    for (int c = 0; c < 4 * S + 4; c++) begin
      @(negedge clk);
      if (bus.digit_sel == 4'b0001 && prev != 4'b0001) begin
        found = 1'b1;
        break;
      end
      prev = bus.digit_sel;
    end
    check($sformatf("scan_start v=%0d", v), int'(found), 1);
    if (found) begin
      for (int k = 0; k < 4 * S; k++) begin
        if (k > 0) @(negedge clk);
        idx  = k / S;
        expw = ((1 << idx) << 5) | (digit_of(v, idx) << 1) | rbi_of(v, idx);
        got  = int'({bus.digit_sel, bus.data, bus.RBI});
        check($sformatf("scan v=%0d cyc=%0d {sel,data,rbi}", v, k), got, expw);
      end
    end
  endtask

  initial begin : monitor
    bit prev_busy, prev_rst, trig;
    int v;
    prev_busy = 1'b0;
    prev_rst  = 1'b0;
    forever begin
      @(negedge clk);
      trig = (prev_busy && !bus.busy && rst_n) || (!prev_rst && rst_n);
      prev_busy = bus.busy;
      prev_rst  = rst_n;
      if (trig) begin
        mon_active = 1'b1;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_publish: display updated with nothing queued");
        end else begin
          v = exp_q.pop_front();
          check_scan(v);
        end
        prev_busy  = bus.busy;
        prev_rst   = rst_n;
        mon_active = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int  c = 0;
    bit  idle;
    do begin
      @(posedge clk);
      c++;
      idle = !bus.busy && exp_q.size() == 0 && !mon_active;
    end while (!idle && c < 2000);
    if (!idle) begin
      n_total++;
      $display("FAIL wait_idle: still busy after %0d cycles, queue=%0d", c, exp_q.size());
    end
  endtask

  // Leaves the bench at #1 after the edge that sampled update.
  task automatic do_update(input int v);
    @(posedge clk); #1;
    bus.value  = 14'(v);
    bus.update = 1'b1;
    @(posedge clk); #1;
    bus.update = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_sel"},  int'(bus.digit_sel), 1);
    check({tag, "_data"}, int'(bus.data), 0);
    check({tag, "_rbi"},  int'(bus.RBI), 0);
    check({tag, "_lt"},   int'(bus.LT), 0);
    check({tag, "_bi"},   int'(bus.BI), 0);
  endtask

  initial begin : stim
    int n, v, chg, idx;
    logic [3:0] prev;
    bus.value     = '0;
    bus.update    = 1'b0;
    bus.lamp_test = 1'b0;
    bus.blank     = 1'b0;

    exp_q.push_back(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    rst_n = 1'b1;
    wait_idle();

    exp_q.push_back(1234);
    do_update(1234);
    n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_len_1234", n, 14);
    wait_idle();

    foreach (dir_vals[i]) begin
      exp_q.push_back(dir_vals[i]);
      do_update(dir_vals[i]);
      wait_idle();
    end

    for (int r = 0; r < 10; r++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99))
                                      : int'($urandom_range(0, 16383));
      exp_q.push_back(v);
      do_update(v);
      wait_idle();
    end

    // Back-to-back: 1234 publishes, 5678 is overwritten by 4321 while pending.
    exp_q.push_back(4321);
    do_update(1234);
    n = 0;
    while (bus.busy && n < 100) begin
      bus.update = 1'b0;
      if (n == 4) begin bus.value = 14'd5678; bus.update = 1'b1; end
      if (n == 7) begin bus.value = 14'd4321; bus.update = 1'b1; end
      if (n >= 15) begin
        idx = sel_index(bus.digit_sel);
        check($sformatf("b2b_interim n=%0d {sel,data}", n), int'({bus.digit_sel, bus.data}),
              ((1 << idx) << 4) | digit_of(1234, idx));
      end
      @(posedge clk); #1;
      n++;
    end
    bus.update = 1'b0;
    check("busy_len_b2b", n, 28);
    wait_idle();

    @(posedge clk); #1;
    bus.lamp_test = 1'b1;
    bus.blank     = 1'b1;
    @(posedge clk); #1;
    check("lamp_lt", int'(bus.LT), 1);
    check("lamp_bi", int'(bus.BI), 0);
    prev = bus.digit_sel;
    chg  = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (bus.digit_sel != prev) chg++;
      prev = bus.digit_sel;
    end
    check("scan_during_lamp", chg, 4);
    bus.lamp_test = 1'b0;
    @(posedge clk); #1;
    check("blank_lt", int'(bus.LT), 0);
    check("blank_bi", int'(bus.BI), 1);
    bus.blank = 1'b0;
    @(posedge clk); #1;
    check("unblank_bi", int'(bus.BI), 0);

    // Reset in the middle of a conversion must leave 0000 on the display.
    do_update(5555);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_q.push_back(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle();

    exp_q.push_back(42);
    do_update(42);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
